// File: rtl/pc_flow_ctrl_if.sv
// pc_flow_ctrl_if: EX jump/stall requests in, fetch address and pipeline flush/hold out.
interface pc_flow_ctrl_if #(parameter int CNT_W = 16);
    logic             jump_en_i;
    logic [31:0]      jump_addr_i;
    logic             hold_flag_i;
    logic             hold_ext_i;
    logic [31:0]      pc_o;
    logic             pc_valid_o;
    logic             flush_o;
    logic             hold_o;
    logic             misalign_o;
    logic [CNT_W-1:0] jump_cnt_o;
    modport master (output jump_en_i, jump_addr_i, hold_flag_i, hold_ext_i,
                    input  pc_o, pc_valid_o, flush_o, hold_o, misalign_o, jump_cnt_o);
    modport slave  (input  jump_en_i, jump_addr_i, hold_flag_i, hold_ext_i,
                    output pc_o, pc_valid_o, flush_o, hold_o, misalign_o, jump_cnt_o);
endinterface

// File: rtl/pc_flow_ctrl.sv
// pc_flow_ctrl: program counter owner; applies EX jumps, defers jumps seen under bus stall,
// and drives flush/hold to the if_id and id_ex pipeline registers.
module pc_flow_ctrl #(
    parameter logic [31:0] RESET_ADDR  = 32'h0000_0000,
    parameter int unsigned FLUSH_EXTRA = 0,
    parameter int          CNT_W       = 16
) (
    input logic           clk,
    input logic           rst,
    pc_flow_ctrl_if.slave bus
);
    typedef enum logic [1:0] {BOOT, RUN, FLUSH, HOLD} state_t;
    localparam logic [2:0] FX = 3'(FLUSH_EXTRA);
    state_t           r_state, w_state;
    logic [31:0]      r_pc, w_pc, r_pend_addr, w_pend_addr, w_target;
    logic [CNT_W-1:0] r_cnt, w_cnt;
    logic [2:0]       r_fcnt, w_fcnt;
    logic             r_valid, r_misalign, w_misalign, r_pend, w_pend, w_flush, w_hold;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= BOOT;
            r_pc        <= RESET_ADDR;
            r_valid     <= 1'b0;
            r_misalign  <= 1'b0;
            r_cnt       <= '0;
            r_pend      <= 1'b0;
            r_pend_addr <= '0;
            r_fcnt      <= '0;
        end else begin
            r_state     <= w_state;
            r_pc        <= w_pc;
            r_valid     <= 1'b1;
            r_misalign  <= w_misalign;
            r_cnt       <= w_cnt;
            r_pend      <= w_pend;
            r_pend_addr <= w_pend_addr;
            r_fcnt      <= w_fcnt;
        end
    end
    // A live EX jump overrides a deferred one
    assign w_target = bus.jump_en_i ? bus.jump_addr_i : r_pend_addr;
    always_comb begin
        w_state     = r_state;
        w_pc        = r_pc;
        w_misalign  = r_misalign;
        w_cnt       = r_cnt;
        w_pend      = r_pend;
        w_pend_addr = r_pend_addr;
        w_fcnt      = r_fcnt;
        w_flush     = 1'b0;
        w_hold      = 1'b0;
        if (r_state == BOOT) begin
            w_flush = 1'b1;
            w_state = RUN;
        end else if (bus.hold_ext_i) begin
            w_hold      = 1'b1;
            w_state     = HOLD;
            w_pend      = r_pend | bus.jump_en_i;
            w_pend_addr = bus.jump_en_i ? bus.jump_addr_i : r_pend_addr;
        end else if (bus.jump_en_i | r_pend) begin
            w_flush    = 1'b1;
            w_pc       = w_target & ~32'h3;
            w_cnt      = r_cnt + CNT_W'(1);
            w_misalign = r_misalign | (|w_target[1:0]);
            w_pend     = 1'b0;
            w_fcnt     = FX;
            w_state    = (FX != 3'd0) ? FLUSH : RUN;
        end else if (bus.hold_flag_i) begin
            w_hold  = 1'b1;
            w_state = HOLD;
        end else begin
            w_pc    = r_pc + 32'd4;
            w_flush = (r_state == FLUSH);
            w_fcnt  = (r_state == FLUSH) ? r_fcnt - 3'd1 : r_fcnt;
            w_state = (r_state == FLUSH && r_fcnt > 3'd1) ? FLUSH : RUN;
        end
    end
    assign bus.pc_o       = r_pc;
    assign bus.pc_valid_o = r_valid;
    assign bus.flush_o    = w_flush;
    assign bus.hold_o     = w_hold;
    assign bus.misalign_o = r_misalign;
    assign bus.jump_cnt_o = r_cnt;
endmodule
